// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types and seed helper for the LED pattern sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int SEED_W = 64;

  // Callers truncate the result to their own LED width.
  function automatic logic [SEED_W-1:0] seed_f(mode_t m, int n);
    logic [SEED_W-1:0] s;
    s = '0;
    case (m)
      MODE_SHIFT, MODE_BOUNCE: s = SEED_W'(1);
      MODE_COUNT:              s = '0;
      default:                 s = (n >= SEED_W) ? '1 : ((SEED_W'(1) << n) - SEED_W'(1));
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - step prescaler: counts run cycles and pulses tick every period_q cycles
module led_prescaler #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 clear,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic [DIV_WIDTH-1:0] period_q, period_d;
  logic [DIV_WIDTH-1:0] period_sat;

  always_comb begin
    period_sat = (period == '0) ? DIV_WIDTH'(1) : period;
    tick       = run && !clear && (count_q == period_q - DIV_WIDTH'(1));
    count_d    = count_q;
    period_d   = period_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d  = '0;
      period_d = period_sat;
    end else if (tick) begin
      // A new period only takes effect at a step boundary.
      count_d  = '0;
      period_d = period_sat;
    end else if (run) begin
      count_d = count_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      period_q <= DIV_WIDTH'(1);
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - run/hold/idle FSM stepping an LED pattern once per prescaled tick
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS    = 8,
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] period,
  output logic [N_LEDS-1:0]    led,
  output logic                 tick,
  output logic                 wrap,
  output logic [1:0]           active_mode
);

  state_t              state_q, state_d;
  logic [N_LEDS-1:0]   led_q, led_d;
  logic                dir_q, dir_d;
  mode_t               amode_q, amode_d;
  mode_t               mode_in;

  logic                run;
  logic                load;
  logic                step;
  logic [N_LEDS-1:0]   nxt_led;
  logic                nxt_dir;
  logic                pat_wrap;

  assign mode_in     = mode_t'(mode);
  assign run         = (state_q == ST_RUN) && en && !clr;
  assign load        = (state_q == ST_IDLE) && en && !clr;
  assign led         = led_q;
  assign active_mode = amode_q;

  led_prescaler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .clear  (clr),
    .load   (load),
    .period (period),
    .tick   (step)
  );

  // Next pattern value for the mode in effect; dir_q=1 means BOUNCE is heading down.
  always_comb begin
    nxt_led  = led_q;
    nxt_dir  = dir_q;
    pat_wrap = 1'b0;
    case (amode_q)
      MODE_SHIFT: begin
        if (led_q == '0) begin
          nxt_led  = N_LEDS'(seed_f(MODE_SHIFT, N_LEDS));
          pat_wrap = 1'b1;
        end else begin
          nxt_led = led_q << 1;
        end
      end
      MODE_BOUNCE: begin
        if (!dir_q) begin
          nxt_led = led_q << 1;
          nxt_dir = nxt_led[N_LEDS-1];
        end else begin
          nxt_led  = led_q >> 1;
          nxt_dir  = !nxt_led[0];
          pat_wrap = nxt_led[0];
        end
      end
      MODE_COUNT: begin
        nxt_led  = led_q + N_LEDS'(1);
        pat_wrap = (nxt_led == '0);
      end
      default: begin
        nxt_led  = ~led_q;
        pat_wrap = &nxt_led;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    dir_d   = dir_q;
    amode_d = amode_q;
    tick    = 1'b0;
    wrap    = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      led_d   = '0;
      dir_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_d = ST_RUN;
            amode_d = mode_in;
            led_d   = N_LEDS'(seed_f(mode_in, N_LEDS));
            dir_d   = 1'b0;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state_d = ST_HOLD;
          end else if (step) begin
            tick = 1'b1;
            if (mode_in != amode_q) begin
              amode_d = mode_in;
              led_d   = N_LEDS'(seed_f(mode_in, N_LEDS));
              dir_d   = 1'b0;
            end else begin
              led_d = nxt_led;
              dir_d = nxt_dir;
              wrap  = pat_wrap;
            end
          end
        end
        ST_HOLD: begin
          if (en) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      led_q   <= '0;
      dir_q   <= 1'b0;
      amode_q <= MODE_SHIFT;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      amode_q <= amode_d;
    end
  end

endmodule
